sha3_result_serializer: RTL and testbench



---
 rtl/sha3_result_pkg.sv | 29 ++
 rtl/sha3_result_slot_buffer.sv | 58 +++++
 rtl/sha3_result_serializer.sv | 117 +++++++++++
 tb/tb_sha3_result_serializer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_result_pkg.sv
// Shared types and helpers for the SHA-3 scan-result serializer.
// Optional trailing checksum word is enabled by SHA3_RESULT_CHECKSUM_EN.
package sha3_result_pkg;

    localparam int DATA_W    = 32;
    localparam int MAX_WORDS = 50;
    localparam logic [7:0] RESULT_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        NONCE,
        HASH,
        CHECK
    } ser_state_e;

    typedef struct packed {
        logic                              valid;
        logic [DATA_W-1:0]                 nonce;
        logic [MAX_WORDS-1:0][DATA_W-1:0]  hash;
    } result_slot_t;

    function automatic logic [DATA_W-1:0] pack_header(input logic [7:0]  magic,
                                                      input logic [7:0]  words,
                                                      input logic [15:0] seq);
        return {magic, words, seq};
    endfunction

endpackage

// File: rtl/sha3_result_slot_buffer.sv
// Two-slot ACTIVE/PENDING result store: captures found results, promotes
// PENDING when the active packet completes, and counts dropped results.
module sha3_result_slot_buffer
    import sha3_result_pkg::*;
(
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             capture,
    input  logic                             promote,
    input  logic [DATA_W-1:0]                nonce,
    input  logic [MAX_WORDS-1:0][DATA_W-1:0] hash,
    output result_slot_t                     active,
    output logic                             pending_valid,
    output logic [15:0]                      drop_count
);

    result_slot_t active_q;
    result_slot_t pending_q;
    result_slot_t incoming;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        incoming       = '0;
        incoming.valid = 1'b1;
        incoming.nonce = nonce;
        incoming.hash  = hash;
    end

    // Promotion frees a slot in the same edge, so a coincident capture never drops.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_q.valid  <= 1'b0;
            pending_q.valid <= 1'b0;
            drop_count      <= '0;
        end else if (promote) begin
            if (pending_q.valid) begin
                active_q <= pending_q;
                if (capture) pending_q <= incoming;
                else         pending_q.valid <= 1'b0;
            end else if (capture) begin
                active_q <= incoming;
            end else begin
                active_q.valid <= 1'b0;
            end
        end else if (capture) begin
            if (!active_q.valid)       active_q   <= incoming;
            else if (!pending_q.valid) pending_q  <= incoming;
            else                       drop_count <= sat_inc(drop_count);
        end
    end

    assign active        = active_q;
    assign pending_valid = pending_q.valid;

endmodule

// File: rtl/sha3_result_serializer.sv
// Frames captured scan results as header/nonce/hash packets on a 32-bit
// valid/ready stream. Define SHA3_RESULT_CHECKSUM_EN to append an XOR checksum word.
module sha3_result_serializer
    import sha3_result_pkg::*;
#(
    parameter int         HASH_WORDS = 50,
    parameter logic [7:0] MAGIC      = RESULT_MAGIC
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             i_valid,
    input  logic                             i_found,
    input  logic [DATA_W-1:0]                i_nonce,
    input  logic [MAX_WORDS-1:0][DATA_W-1:0] i_hash32_hilo,
    output logic                             o_valid,
    output logic [DATA_W-1:0]                o_data,
    output logic                             o_last,
    input  logic                             i_ready,
    output logic                             o_busy,
    output logic [15:0]                      o_drop_count
);

    localparam logic [5:0] LAST_IDX = 6'(HASH_WORDS - 1);

    ser_state_e        state;
    ser_state_e        state_nxt;
    ser_state_e        after_pkt;
    logic [5:0]        word_idx;
    logic [15:0]       seq;
    result_slot_t      active;
    logic              pending_valid;
    logic              capture;
    logic              fire;
`ifdef SHA3_RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    assign capture = i_valid && i_found;
    assign fire    = o_valid && i_ready;
    assign o_busy  = active.valid;

    sha3_result_slot_buffer u_slots (
        .clk           (clk),
        .rstn          (rstn),
        .capture       (capture),
        .promote       (fire && o_last),
        .nonce         (i_nonce),
        .hash          (i_hash32_hilo),
        .active        (active),
        .pending_valid (pending_valid),
        .drop_count    (o_drop_count)
    );

    // Outputs decode from registered state only, so they hold while stalled.
    always_comb begin
        state_nxt = state;
        after_pkt = (pending_valid || capture) ? HEADER : IDLE;
        o_valid   = 1'b0;
        o_last    = 1'b0;
        o_data    = '0;
        case (state)
            IDLE: begin
                if (capture) state_nxt = HEADER;
            end
            HEADER: begin
                o_valid = 1'b1;
                o_data  = pack_header(MAGIC, 8'(HASH_WORDS), seq);
                if (i_ready) state_nxt = NONCE;
            end
            NONCE: begin
                o_valid = 1'b1;
                o_data  = active.nonce;
                if (i_ready) state_nxt = HASH;
            end
            HASH: begin
                o_valid = 1'b1;
                o_data  = active.hash[word_idx];
`ifdef SHA3_RESULT_CHECKSUM_EN
                if (i_ready && word_idx == LAST_IDX) state_nxt = CHECK;
`else
                o_last  = (word_idx == LAST_IDX);
                if (i_ready && o_last) state_nxt = after_pkt;
`endif
            end
`ifdef SHA3_RESULT_CHECKSUM_EN
            CHECK: begin
                o_valid = 1'b1;
                o_data  = csum;
                o_last  = 1'b1;
                if (i_ready) state_nxt = after_pkt;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            seq      <= '0;
            word_idx <= '0;
        end else begin
            state <= state_nxt;
            if (fire && state == HEADER) seq <= seq + 16'd1;
            if (fire && state == NONCE)     word_idx <= '0;
            else if (fire && state == HASH) word_idx <= word_idx + 6'd1;
        end
    end

`ifdef SHA3_RESULT_CHECKSUM_EN
    // Header handshake restarts the running XOR for the new packet.
    always_ff @(posedge clk) begin
        if (fire) csum <= (state == HEADER) ? o_data : (csum ^ o_data);
    end
`endif

endmodule

// File: tb/tb_sha3_result_serializer.sv
// Directed bench for sha3_result_serializer with a packet-level reference model.
// Build with SHA3_RESULT_CHECKSUM_EN to exercise the checksum variant (HASH_WORDS=2).
module tb_sha3_result_serializer;

`ifdef SHA3_RESULT_CHECKSUM_EN
    localparam int HW = 2;
    localparam int NW = HW + 3;
    localparam logic [31:0] EXP_W0    = 32'hA502_0000;
    localparam logic [31:0] EXP_LASTH = 32'h0101_0101;
`else
    localparam int HW = 50;
    localparam int NW = HW + 2;
    localparam logic [31:0] EXP_W0    = 32'hA532_0000;
    localparam logic [31:0] EXP_LASTH = 32'h3131_3131;
`endif
    localparam int MID = (NW > 21) ? 20 : 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_valid = 1'b0;
    logic              i_found = 1'b0;
    logic              i_ready = 1'b0;
    logic [31:0]       i_nonce = '0;
    logic [49:0][31:0] i_hash32_hilo = '0;
    logic              o_valid;
    logic              o_last;
    logic              o_busy;
    logic [31:0]       o_data;
    logic [15:0]       o_drop_count;

    always #5 clk = ~clk;

    sha3_result_serializer #(.HASH_WORDS(HW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_valid       (i_valid),
        .i_found       (i_found),
        .i_nonce       (i_nonce),
        .i_hash32_hilo (i_hash32_hilo),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_busy        (o_busy),
        .o_drop_count  (o_drop_count)
    );

    typedef struct packed {
        logic [31:0]       nonce;
        logic [49:0][31:0] hash;
    } res_t;

    res_t        res_q[$];
    res_t        cap_r;
    int          wpos = 0;
    int          mseq = 0;
    logic [15:0] mdrop = '0;
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    int          obs_cyc[$];
    logic [31:0] saved[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        chk_en = 1'b0;
    logic        p_stall = 1'b0;
    logic [31:0] p_data = '0;
    logic        p_last = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] base_word(input res_t r, input logic [15:0] seq, input int w);
        if (w == 0) return {8'hA5, 8'(HW), seq};
        if (w == 1) return r.nonce;
        return r.hash[w-2];
    endfunction

    // Packet word w of result r: header, nonce, hash words, then optional XOR of all before it.
    function automatic logic [31:0] exp_word(input res_t r, input logic [15:0] seq, input int w);
        logic [31:0] acc;
        if (w < HW + 2) return base_word(r, seq, w);
        acc = '0;
        for (int k = 0; k < HW + 2; k++) acc ^= base_word(r, seq, k);
        return acc;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("o_valid", 32'(o_valid), 32'(res_q.size() != 0));
            check("o_busy", 32'(o_busy), 32'(res_q.size() != 0));
            check("drop_count", 32'(o_drop_count), 32'(mdrop));
            if (res_q.size() != 0) begin
                check("o_data", o_data, exp_word(res_q[0], 16'(mseq), wpos));
                check("o_last", 32'(o_last), 32'(wpos == NW - 1));
            end
            if (p_stall) begin
                check("stall_valid", 32'(o_valid), 32'd1);
                check("stall_data", o_data, p_data);
                check("stall_last", 32'(o_last), 32'(p_last));
            end
        end
        p_stall = o_valid && !i_ready && rstn;
        p_data  = o_data;
        p_last  = o_last;
        if (!rstn) begin
            res_q.delete();
            wpos   = 0;
            mseq   = 0;
            mdrop  = '0;
            chk_en = 1'b1;
        end else begin
            if (res_q.size() != 0 && i_ready) begin
                obs_data.push_back(o_data);
                obs_last.push_back(o_last);
                obs_cyc.push_back(cyc);
                wpos++;
                if (wpos == NW) begin
                    wpos = 0;
                    mseq = (mseq + 1) & 32'hFFFF;
                    void'(res_q.pop_front());
                end
            end
            if (i_valid && i_found) begin
                if (res_q.size() < 2) begin
                    cap_r.nonce = i_nonce;
                    cap_r.hash  = i_hash32_hilo;
                    res_q.push_back(cap_r);
                end else if (mdrop != 16'hFFFF) begin
                    mdrop = mdrop + 16'd1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_res(input logic [31:0] n, input logic [31:0] salt);
        i_nonce = n;
        for (int k = 0; k < 50; k++) i_hash32_hilo[k] = (32'(k) * 32'h0101_0101) ^ salt;
    endtask

    task automatic capture1(input logic [31:0] n, input logic [31:0] salt);
        set_res(n, salt);
        i_valid = 1'b1;
        i_found = 1'b1;
        step();
        i_valid = 1'b0;
        i_found = 1'b0;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        i_valid = 1'b0;
        i_found = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while ((o_valid || o_busy) && n < budget) begin
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        i_ready = 1'b1;
        check("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int nlast;
        int n;
        step();
        step();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_drop", 32'(o_drop_count), 32'd0);
        rstn    = 1'b1;
        i_ready = 1'b1;
        step();

        // Single result, always ready.
        clear_obs();
        capture1(32'h0000_1234, 32'h0);
        wait_idle(200, 1'b0);
        check("t1_count", 32'(obs_data.size()), 32'(NW));
        check("t1_word0", obs_data[0], EXP_W0);
        check("t1_word1", obs_data[1], 32'h0000_1234);
        check("t1_lasthash", obs_data[HW+1], EXP_LASTH);
        check("t1_last_end", 32'(obs_last[NW-1]), 32'd1);
        check("t1_last_early", 32'(obs_last[NW-2]), 32'd0);
        check("t1_contig", 32'(obs_cyc[NW-1] - obs_cyc[0]), 32'(NW - 1));
`ifdef SHA3_RESULT_CHECKSUM_EN
        check("t1_csum", obs_data[4], 32'hA403_1335);
`endif
        saved = obs_data;

        // Not-found results are ignored.
        clear_obs();
        set_res(32'hDEAD_BEEF, 32'h5A5A_5A5A);
        i_valid = 1'b1;
        i_found = 1'b0;
        for (int i = 0; i < 10; i++) step();
        i_valid = 1'b0;
        check("t2_drop", 32'(o_drop_count), 32'd0);
        check("t2_words", 32'(obs_data.size()), 32'd0);

        // Three back-to-back captures while stalled: third drops.
        do_reset();
        clear_obs();
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_res(32'hA000_0000 + 32'(i), 32'(i) << 8);
            i_valid = 1'b1;
            i_found = 1'b1;
            step();
        end
        i_valid = 1'b0;
        i_found = 1'b0;
        step();
        check("t3_drop", 32'(o_drop_count), 32'd1);
        wait_idle(400, 1'b0);
        check("t3_count", 32'(obs_data.size()), 32'(2 * NW));
        check("t3_hdr0", obs_data[0], EXP_W0);
        check("t3_nonce0", obs_data[1], 32'hA000_0000);
        check("t3_hdr1", obs_data[NW], EXP_W0 | 32'd1);
        check("t3_nonce1", obs_data[NW+1], 32'hA000_0001);
        check("t3_no_gap", 32'(obs_cyc[NW] - obs_cyc[NW-1]), 32'd1);

        // Random backpressure: same content as the always-ready run.
        do_reset();
        clear_obs();
        i_ready = 1'b0;
        capture1(32'h0000_1234, 32'h0);
        wait_idle(2000, 1'b1);
        check("t4_count", 32'(obs_data.size()), 32'(NW));
        for (int i = 0; i < NW; i++) check("t4_word", obs_data[i], saved[i]);

        // Capture on the final handshake with PENDING full.
        do_reset();
        clear_obs();
        i_ready = 1'b1;
        capture1(32'hB000_0000, 32'h1);
        capture1(32'hB000_0001, 32'h2);
        n = 0;
        while (!(o_valid && o_last) && n < 200) begin
            step();
            n++;
        end
        check("t5_reach_last", 32'(n < 200), 32'd1);
        capture1(32'hB000_0002, 32'h3);
        wait_idle(400, 1'b0);
        nlast = 0;
        foreach (obs_last[i]) if (obs_last[i]) nlast++;
        check("t5_drop", 32'(o_drop_count), 32'd0);
        check("t5_packets", 32'(nlast), 32'd3);
        check("t5_nonce2", obs_data[2*NW+1], 32'hB000_0002);
        check("t5_hdr2", obs_data[2*NW], EXP_W0 | 32'd2);

        // Reset mid-packet, then a fresh packet restarts at seq 0.
        do_reset();
        clear_obs();
        i_ready = 1'b1;
        capture1(32'hC000_0000, 32'h4);
        n = 0;
        while (obs_data.size() < MID && n < 200) begin
            step();
            n++;
        end
        check("t6_reach_mid", 32'(obs_data.size()), 32'(MID));
        rstn = 1'b0;
        step();
        check("t6_rst_valid", 32'(o_valid), 32'd0);
        check("t6_rst_busy", 32'(o_busy), 32'd0);
        rstn = 1'b1;
        clear_obs();
        capture1(32'hC000_0001, 32'h5);
        wait_idle(200, 1'b0);
        check("t6_count", 32'(obs_data.size()), 32'(NW));
        check("t6_hdr", obs_data[0], EXP_W0);
        check("t6_nonce", obs_data[1], 32'hC000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
